// File: rtl/instr_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ifu_pkg;

  typedef enum logic [1:0] {
    IFU_IDLE  = 2'd0,
    IFU_RUN   = 2'd1,
    IFU_DRAIN = 2'd2
  } ifu_state_e;

  localparam int unsigned PC_INCR = 4;
  localparam int unsigned INSTR_W = 32;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

endpackage

// File: rtl/instr_fetch_unit_fifo.sv
// Small register-based FIFO holding fetched {instruction, address} entries.
// Synchronous reset and flush; flush wins over a coincident push.
module ifu_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 64
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  output logic [WIDTH-1:0]             head_data,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    do_push  = push && (cnt_q != CNT_W'(DEPTH));
    do_pop   = pop && (cnt_q != '0);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = ptr_inc(wr_ptr_q);
      end
      if (do_pop) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      case ({do_push, do_pop})
        2'b10:   cnt_d = cnt_q + CNT_W'(1);
        2'b01:   cnt_d = cnt_q - CNT_W'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign head_data = mem_q[rd_ptr_q];
  assign count     = cnt_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, issues in-order fetches under a
// credit limit of DEPTH (outstanding + buffered), buffers returned words and
// presents them to decode. Redirects flush the buffer and discard responses
// to requests already in flight.
// Optional: define IFU_STALL_CNT_EN to add the stall_cycles counter output.
module instr_fetch_unit
  import ifu_pkg::*;
#(
  parameter int unsigned        ADDR_W   = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0,
  parameter int unsigned        DEPTH    = 2
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [ADDR_W-1:0]  imem_req_addr,
  input  logic               imem_rsp_valid,
  input  logic [31:0]        imem_rsp_data,
  output logic [31:0]        I,
  output logic               I_valid,
  input  logic               I_ready,
  output logic [ADDR_W-1:0]  I_pc,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc
`ifdef IFU_STALL_CNT_EN
  ,
  output logic [31:0]        stall_cycles
`endif
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned ENT_W = INSTR_W + ADDR_W;

  ifu_state_e        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] rsp_pc_q, rsp_pc_d;
  logic [CNT_W-1:0]  outst_q, outst_d;
  logic [CNT_W-1:0]  drop_q, drop_d;

  logic [CNT_W-1:0]  fifo_count;
  logic [ENT_W-1:0]  fifo_head;
  logic              fifo_push, fifo_pop;
  logic [CNT_W:0]    credit_used;
  logic [CNT_W:0]    drop_total;
  logic [ADDR_W-1:0] redir_pc;
  logic              req_fire;

  // Request issue: only in RUN and only while credits remain.
  always_comb begin
    credit_used    = {1'b0, outst_q} + {1'b0, fifo_count};
    imem_req_valid = (state_q == IFU_RUN) && (credit_used < (CNT_W+1)'(DEPTH));
    req_fire       = imem_req_valid && imem_req_ready;
    redir_pc       = redirect_pc & ~ADDR_W'(3);
  end

  // Next-state for PC, credit counters and fetch FSM.
  // On redirect every request still in flight (already-squashed, outstanding,
  // and one accepted this cycle) becomes a response to discard.
  always_comb begin
    pc_d       = pc_q;
    rsp_pc_d   = rsp_pc_q;
    outst_d    = outst_q;
    drop_d     = drop_q;
    state_d    = state_q;
    fifo_push  = 1'b0;
    drop_total = {1'b0, drop_q} + {1'b0, outst_q}
               + (CNT_W+1)'(req_fire) - (CNT_W+1)'(imem_rsp_valid);
    if (req_fire) begin
      pc_d    = pc_q + ADDR_W'(PC_INCR);
      outst_d = outst_q + CNT_W'(1);
    end
    if (redirect_valid) begin
      pc_d     = redir_pc;
      rsp_pc_d = redir_pc;
      outst_d  = '0;
      drop_d   = drop_total[CNT_W-1:0];
      state_d  = (drop_total == '0) ? IFU_RUN : IFU_DRAIN;
    end else begin
      case (state_q)
        IFU_IDLE: state_d = IFU_RUN;
        IFU_RUN: begin
          if (imem_rsp_valid) begin
            fifo_push = 1'b1;
            outst_d   = outst_d - CNT_W'(1);
            rsp_pc_d  = rsp_pc_q + ADDR_W'(PC_INCR);
          end
        end
        IFU_DRAIN: begin
          if (imem_rsp_valid) begin
            drop_d = drop_q - CNT_W'(1);
            if (drop_q == CNT_W'(1)) state_d = IFU_RUN;
          end
        end
        default: state_d = IFU_IDLE;
      endcase
    end
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IFU_IDLE;
      pc_q     <= RESET_PC;
      rsp_pc_q <= RESET_PC;
      outst_q  <= '0;
      drop_q   <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      rsp_pc_q <= rsp_pc_d;
      outst_q  <= outst_d;
      drop_q   <= drop_d;
    end
  end

  assign fifo_pop = I_valid && I_ready;

  ifu_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENT_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .push      (fifo_push),
    .push_data ({imem_rsp_data, rsp_pc_q}),
    .pop       (fifo_pop),
    .head_data (fifo_head),
    .count     (fifo_count)
  );

  // Decode-side outputs come straight from the buffer head registers.
  always_comb begin
    imem_req_addr = pc_q;
    I_valid       = (fifo_count != '0);
    I             = I_valid ? fifo_head[ENT_W-1 -: INSTR_W] : NOP_INSTR;
    I_pc          = I_valid ? fifo_head[ADDR_W-1:0] : '0;
  end

`ifdef IFU_STALL_CNT_EN
  logic [31:0] stall_q, stall_d;

  // Count cycles where decode wants an instruction but none is ready.
  always_comb begin
    stall_d = stall_q;
    if (I_ready && !I_valid && (state_q == IFU_RUN || state_q == IFU_DRAIN)
        && (stall_q != '1)) begin
      stall_d = stall_q + 32'd1;
    end
  end

  // Stall counter register.
  always_ff @(posedge clk) begin
    if (rst) stall_q <= '0;
    else     stall_q <= stall_d;
  end

  assign stall_cycles = stall_q;
`endif

`ifndef SYNTHESIS
  rsp_has_owner: assert property (@(posedge clk) disable iff (rst)
    imem_rsp_valid |-> ((outst_q != '0) || (drop_q != '0)));
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed table, corner sequences
// and randomized traffic against an in-order memory and a stream-level model.
module tb_instr_fetch_unit;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready;
  logic [31:0] req_addr;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic [31:0] I_w;
  logic        I_valid, I_ready;
  logic [31:0] I_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  logic        w_req_valid;
  logic        w_req_ready;
  logic [31:0] w_req_addr;
  logic [31:0] w_I;
  logic        w_I_valid;
  logic [31:0] w_I_pc;
  logic        w_zero;
  logic [31:0] w_zero32;
`ifdef IFU_STALL_CNT_EN
  logic [31:0] stall_cycles, w_stall;
`endif

  instr_fetch_unit #(.ADDR_W(32), .RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(req_valid), .imem_req_ready(req_ready), .imem_req_addr(req_addr),
    .imem_rsp_valid(rsp_valid), .imem_rsp_data(rsp_data),
    .I(I_w), .I_valid(I_valid), .I_ready(I_ready), .I_pc(I_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
`ifdef IFU_STALL_CNT_EN
    , .stall_cycles(stall_cycles)
`endif
  );

  instr_fetch_unit #(.ADDR_W(32), .RESET_PC(32'hFFFF_FFFC), .DEPTH(DEPTH)) dut_wrap (
    .clk(clk), .rst(rst),
    .imem_req_valid(w_req_valid), .imem_req_ready(w_req_ready), .imem_req_addr(w_req_addr),
    .imem_rsp_valid(w_zero), .imem_rsp_data(w_zero32),
    .I(w_I), .I_valid(w_I_valid), .I_ready(w_zero), .I_pc(w_I_pc),
    .redirect_valid(w_zero), .redirect_pc(w_zero32)
`ifdef IFU_STALL_CNT_EN
    , .stall_cycles(w_stall)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0: return 32'h8C00_0000;
      32'h4: return 32'hAC00_0000;
      32'h8: return 32'h1000_0000;
      default: return {a[15:0] ^ 16'h5A5A, a[15:0]};
    endcase
  endfunction

  // Stream-level model: pending memory requests tagged with a redirect epoch.
  typedef struct {
    logic [31:0] addr;
    int          due;
    int          epoch;
  } req_t;

  req_t        pq[$];
  int          epoch, buffered, last_due;
  logic [31:0] exp_fetch, exp_consume;
  bit          in_idle, prev_redir;
  logic [31:0] act_acc[$], act_pop[$];
`ifdef IFU_STALL_CNT_EN
  logic [31:0] stall_exp;
`endif

  bit          manual;
  bit          m_rdy, m_irdy, m_redir;
  logic [31:0] m_target;
  int          rdy_pct, irdy_pct, redir_pct, lat_min, lat_max;

  task automatic do_reset();
    rst = 1'b1;
    req_ready = 1'b0; rsp_valid = 1'b0; rsp_data = '0;
    I_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    @(negedge clk);
    @(negedge clk);
    check("rst_req_valid", req_valid, 0);
    check("rst_req_addr", req_addr, 32'h0);
    check("rst_I", I_w, 0);
    check("rst_I_valid", I_valid, 0);
    check("rst_I_pc", I_pc, 0);
    check("rst_wrap_addr", w_req_addr, 32'hFFFF_FFFC);
`ifdef IFU_STALL_CNT_EN
    check("rst_stall", stall_cycles, 0);
    stall_exp = '0;
`endif
    pq.delete(); act_acc.delete(); act_pop.delete();
    epoch = 0; buffered = 0; last_due = -1;
    exp_fetch = 32'h0; exp_consume = 32'h0;
    in_idle = 1'b1; prev_redir = 1'b0;
    rst = 1'b0;
    cyc = 0;
  endtask

  // One clock cycle: check outputs against the model, drive inputs, update.
  task automatic cycle();
    int   stale, live, lat, due;
    bit   exp_rv, exp_iv;
    req_t r;
    stale = 0; live = 0;
    foreach (pq[i]) begin
      if (pq[i].epoch != epoch) stale++;
      else live++;
    end
    exp_rv = !in_idle && (stale == 0) && (live + buffered < DEPTH);
    exp_iv = (buffered > 0);
    check("req_valid", req_valid, exp_rv);
    if (exp_rv) check("req_addr", req_addr, exp_fetch);
    check("I_valid", I_valid, exp_iv);
    if (exp_iv) begin
      check("I_pc", I_pc, exp_consume);
      check("I", I_w, mem_word(exp_consume));
    end
`ifdef IFU_STALL_CNT_EN
    check("stall_cycles", stall_cycles, stall_exp);
`endif
    if (pq.size() > 0 && pq[0].due <= cyc) begin
      rsp_valid = 1'b1;
      rsp_data  = mem_word(pq[0].addr);
    end else begin
      rsp_valid = 1'b0;
      rsp_data  = $urandom;
    end
    if (manual) begin
      req_ready      = m_rdy;
      I_ready        = m_irdy;
      redirect_valid = m_redir;
      redirect_pc    = m_target;
    end else begin
      req_ready      = ($urandom_range(99) < rdy_pct);
      I_ready        = ($urandom_range(99) < irdy_pct);
      redirect_valid = !prev_redir && ($urandom_range(99) < redir_pct);
      redirect_pc    = $urandom & 32'h0000_0FFF;
    end
    if (req_valid && req_ready) act_acc.push_back(req_addr);
    if (I_valid && I_ready) act_pop.push_back(I_pc);
`ifdef IFU_STALL_CNT_EN
    if (I_ready && !exp_iv && !in_idle) stall_exp++;
`endif
    if (rsp_valid) begin
      r = pq.pop_front();
      if (r.epoch == epoch) buffered++;
    end
    if (exp_iv && I_ready) begin
      exp_consume += 32'd4;
      buffered--;
    end
    if (exp_rv && req_ready) begin
      lat = $urandom_range(lat_max, lat_min);
      due = cyc + lat;
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      r.addr = exp_fetch; r.due = due; r.epoch = epoch;
      pq.push_back(r);
      exp_fetch += 32'd4;
    end
    if (redirect_valid) begin
      exp_fetch   = redirect_pc & ~32'd3;
      exp_consume = redirect_pc & ~32'd3;
      buffered    = 0;
      epoch++;
    end
    prev_redir = redirect_valid;
    in_idle    = 1'b0;
    @(negedge clk);
    cyc++;
  endtask

  typedef struct {
    bit          rdy, rsp_v;
    logic [31:0] rsp_d;
    bit          irdy;
    bit          e_rv;
    logic [31:0] e_addr;
    bit          e_iv;
    logic [31:0] e_i, e_pc;
  } vec_t;

  vec_t vecs[8];
  bit   irdy_seq[8];

  initial begin
    w_req_ready = 1'b1; w_zero = 1'b0; w_zero32 = '0;
    manual = 1'b1; m_rdy = 1'b0; m_irdy = 1'b0; m_redir = 1'b0; m_target = '0;
    rdy_pct = 100; irdy_pct = 100; redir_pct = 0; lat_min = 1; lat_max = 1;

    // Directed 1-cycle memory sequence, one row per cycle after reset release.
    vecs[0] = '{1, 0, 32'h0,         1, 0, 32'h00, 0, 32'h0,         32'h0};
    vecs[1] = '{1, 0, 32'h0,         1, 1, 32'h00, 0, 32'h0,         32'h0};
    vecs[2] = '{1, 1, 32'h8C00_0000, 1, 1, 32'h04, 0, 32'h0,         32'h0};
    vecs[3] = '{1, 1, 32'hAC00_0000, 1, 0, 32'h08, 1, 32'h8C00_0000, 32'h0};
    vecs[4] = '{1, 0, 32'h0,         1, 1, 32'h08, 1, 32'hAC00_0000, 32'h4};
    vecs[5] = '{1, 1, 32'h1000_0000, 1, 1, 32'h0C, 0, 32'h0,         32'h0};
    vecs[6] = '{1, 1, 32'h0000_0013, 1, 0, 32'h10, 1, 32'h1000_0000, 32'h8};
    vecs[7] = '{1, 0, 32'h0,         1, 1, 32'h10, 1, 32'h0000_0013, 32'hC};

    do_reset();
    for (int k = 0; k < 8; k++) begin
      req_ready = vecs[k].rdy; rsp_valid = vecs[k].rsp_v;
      rsp_data = vecs[k].rsp_d; I_ready = vecs[k].irdy;
      check($sformatf("tbl%0d_req_valid", k), req_valid, vecs[k].e_rv);
      check($sformatf("tbl%0d_req_addr", k), req_addr, vecs[k].e_addr);
      check($sformatf("tbl%0d_I_valid", k), I_valid, vecs[k].e_iv);
      if (vecs[k].e_iv) begin
        check($sformatf("tbl%0d_I", k), I_w, vecs[k].e_i);
        check($sformatf("tbl%0d_I_pc", k), I_pc, vecs[k].e_pc);
      end
      check($sformatf("wrap%0d_I_valid", k), w_I_valid, 0);
      if (k == 0) begin
        check("wrap_I_empty", w_I, 0);
        check("wrap_I_pc_empty", w_I_pc, 0);
      end
      if (k == 1) begin
        check("wrap_first_valid", w_req_valid, 1);
        check("wrap_first_addr", w_req_addr, 32'hFFFF_FFFC);
      end
      if (k == 2) begin
        check("wrap_second_valid", w_req_valid, 1);
        check("wrap_second_addr", w_req_addr, 32'h0000_0000);
      end
      @(negedge clk);
      cyc++;
    end

    // Decode stalled: only DEPTH requests, then resume at 0x8.
    do_reset();
    manual = 1'b1; m_rdy = 1'b1; m_irdy = 1'b0; m_redir = 1'b0;
    lat_min = 1; lat_max = 1;
    repeat (8) cycle();
    check("stall_nreq", act_acc.size(), 2);
    if (act_acc.size() >= 2) begin
      check("stall_req0", act_acc[0], 32'h0);
      check("stall_req1", act_acc[1], 32'h4);
    end
    check("stall_hold_req_valid", req_valid, 0);
    m_irdy = 1'b1;
    repeat (5) cycle();
    check("resume_nreq_ge3", act_acc.size() >= 3, 1);
    if (act_acc.size() >= 3) check("resume_addr", act_acc[2], 32'h8);

    // 3-cycle memory, redirect with two requests outstanding.
    do_reset();
    manual = 1'b1; m_rdy = 1'b1; m_irdy = 1'b1; m_redir = 1'b0;
    lat_min = 3; lat_max = 3;
    repeat (3) cycle();
    check("drain_pre_req_valid", req_valid, 0);
    m_redir = 1'b1; m_target = 32'h40;
    cycle();
    m_redir = 1'b0;
    act_acc.delete(); act_pop.delete();
    repeat (12) cycle();
    check("drain_got_fetch", act_acc.size() > 0, 1);
    if (act_acc.size() > 0) check("drain_first_fetch", act_acc[0], 32'h40);
    check("drain_got_instr", act_pop.size() > 0, 1);
    if (act_pop.size() > 0) check("drain_first_I_pc", act_pop[0], 32'h40);

    // Redirect coincident with handshake of 0x8 and an accepted request.
    do_reset();
    manual = 1'b1; m_rdy = 1'b1; m_redir = 1'b0;
    lat_min = 1; lat_max = 1;
    irdy_seq = '{0, 0, 0, 0, 1, 0, 0, 1};
    for (int k = 0; k < 8; k++) begin
      m_irdy = irdy_seq[k];
      cycle();
    end
    check("coinc_I_valid", I_valid, 1);
    check("coinc_I_pc", I_pc, 32'h8);
    check("coinc_req_valid", req_valid, 1);
    act_acc.delete(); act_pop.delete();
    m_irdy = 1'b1; m_redir = 1'b1; m_target = 32'h100;
    cycle();
    m_redir = 1'b0;
    check("coinc_consumed", act_pop.size() > 0 ? act_pop[0] : 32'hDEAD_BEEF, 32'h8);
    check("coinc_accepted", act_acc.size() > 0 ? act_acc[0] : 32'hDEAD_BEEF, 32'hC);
    check("coinc_drain_req_valid", req_valid, 0);
    check("coinc_flushed", I_valid, 0);
    act_acc.delete(); act_pop.delete();
    repeat (8) cycle();
    if (act_acc.size() > 0) check("coinc_next_fetch", act_acc[0], 32'h100);
    else check("coinc_next_fetch", 32'hDEAD_BEEF, 32'h100);
    if (act_pop.size() > 0) check("coinc_next_I_pc", act_pop[0], 32'h100);
    else check("coinc_next_I_pc", 32'hDEAD_BEEF, 32'h100);

`ifdef IFU_STALL_CNT_EN
    // Memory never ready for 10 RUN cycles with decode waiting.
    do_reset();
    manual = 1'b1; m_rdy = 1'b0; m_irdy = 1'b1; m_redir = 1'b0;
    repeat (11) cycle();
    check("stall_exact", stall_cycles, 32'd10);
`endif

    // Randomized traffic.
    do_reset();
    manual = 1'b0;
    rdy_pct = 70; irdy_pct = 60; redir_pct = 4; lat_min = 1; lat_max = 4;
    repeat (1500) cycle();
    rdy_pct = 100; irdy_pct = 100; redir_pct = 10; lat_min = 1; lat_max = 2;
    repeat (500) cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
